// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle Harvard MIPS-I core.
package mips_pkg;

  localparam logic [31:0] ResetVector = 32'hBFC0_0000;

  typedef enum logic [5:0] {
    OpSpecial = 6'h00,
    OpJ       = 6'h02,
    OpJal     = 6'h03,
    OpBeq     = 6'h04,
    OpBne     = 6'h05,
    OpAddiu   = 6'h09,
    OpSlti    = 6'h0a,
    OpSltiu   = 6'h0b,
    OpAndi    = 6'h0c,
    OpOri     = 6'h0d,
    OpXori    = 6'h0e,
    OpLui     = 6'h0f,
    OpLw      = 6'h23,
    OpSw      = 6'h2b
  } opcode_e;

  typedef enum logic [5:0] {
    FnSll   = 6'h00,
    FnSrl   = 6'h02,
    FnSra   = 6'h03,
    FnJr    = 6'h08,
    FnJalr  = 6'h09,
    FnMfhi  = 6'h10,
    FnMthi  = 6'h11,
    FnMflo  = 6'h12,
    FnMtlo  = 6'h13,
    FnMult  = 6'h18,
    FnMultu = 6'h19,
    FnAddu  = 6'h21,
    FnSubu  = 6'h23,
    FnAnd   = 6'h24,
    FnOr    = 6'h25,
    FnXor   = 6'h26,
    FnSlt   = 6'h2a,
    FnSltu  = 6'h2b
  } funct_e;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two async read ports, one sync write port, $0 fixed at 0.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  output logic [31:0] reg_v0_o
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we_i && (waddr_i != 5'd0)) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
  assign reg_v0_o  = regs_q[2];

endmodule

// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS-I subset core with separate instruction/data buses and one branch delay slot.
module mips_cpu_harvard
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  logic [31:0] pc_q, pc_d, npc_q, npc_d, hi_q, hi_d, lo_q, lo_d;
  logic        active_q, active_d, update;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  assign opcode = instr_readdata[31:26];
  assign rs     = instr_readdata[25:21];
  assign rt     = instr_readdata[20:16];
  assign rd     = instr_readdata[15:11];
  assign shamt  = instr_readdata[10:6];
  assign funct  = instr_readdata[5:0];
  assign imm    = instr_readdata[15:0];
  assign target = instr_readdata[25:0];

  logic [31:0] rs_val, rt_val, imm_sext, imm_zext, pc_plus4, pc_plus8, br_target, j_target;
  logic [63:0] prod_signed, prod_unsigned;
  logic        wb_en, jump_taken;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, jump_target;

  assign update    = clk_enable && active_q;
  assign imm_sext  = {{16{imm[15]}}, imm};
  assign imm_zext  = {16'd0, imm};
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_plus8  = pc_q + 32'd8;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], target, 2'b00};
  // Explicit 64-bit extension keeps the low 64 bits of the product exact for both signednesses.
  assign prod_signed   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_unsigned = {32'd0, rs_val} * {32'd0, rt_val};

  mips_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (wb_en && update),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val),
    .reg_v0_o  (register_v0)
  );

  always_comb begin
    wb_en       = 1'b0;
    wb_addr     = rd;
    wb_data     = '0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    jump_taken  = 1'b0;
    jump_target = '0;
    data_read   = 1'b0;
    data_write  = 1'b0;
    case (opcode)
      OpSpecial: begin
        case (funct)
          FnSll:   begin wb_en = 1'b1; wb_data = rt_val << shamt; end
          FnSrl:   begin wb_en = 1'b1; wb_data = rt_val >> shamt; end
          FnSra:   begin wb_en = 1'b1; wb_data = $signed(rt_val) >>> shamt; end
          FnJr:    begin jump_taken = 1'b1; jump_target = rs_val; end
          FnJalr:  begin
            jump_taken  = 1'b1;
            jump_target = rs_val;
            wb_en       = 1'b1;
            wb_data     = pc_plus8;
          end
          FnMfhi:  begin wb_en = 1'b1; wb_data = hi_q; end
          FnMflo:  begin wb_en = 1'b1; wb_data = lo_q; end
          FnMthi:  hi_d = rs_val;
          FnMtlo:  lo_d = rs_val;
          FnMult:  {hi_d, lo_d} = prod_signed;
          FnMultu: {hi_d, lo_d} = prod_unsigned;
          FnAddu:  begin wb_en = 1'b1; wb_data = rs_val + rt_val; end
          FnSubu:  begin wb_en = 1'b1; wb_data = rs_val - rt_val; end
          FnAnd:   begin wb_en = 1'b1; wb_data = rs_val & rt_val; end
          FnOr:    begin wb_en = 1'b1; wb_data = rs_val | rt_val; end
          FnXor:   begin wb_en = 1'b1; wb_data = rs_val ^ rt_val; end
          FnSlt:   begin wb_en = 1'b1; wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
          FnSltu:  begin wb_en = 1'b1; wb_data = {31'd0, rs_val < rt_val}; end
          default: ;
        endcase
      end
      OpJ:   begin jump_taken = 1'b1; jump_target = j_target; end
      OpJal: begin
        jump_taken  = 1'b1;
        jump_target = j_target;
        wb_en       = 1'b1;
        wb_addr     = 5'd31;
        wb_data     = pc_plus8;
      end
      OpBeq: begin jump_taken = (rs_val == rt_val); jump_target = br_target; end
      OpBne: begin jump_taken = (rs_val != rt_val); jump_target = br_target; end
      OpAddiu: begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val + imm_sext; end
      OpSlti:  begin
        wb_en   = 1'b1;
        wb_addr = rt;
        wb_data = {31'd0, $signed(rs_val) < $signed(imm_sext)};
      end
      OpSltiu: begin wb_en = 1'b1; wb_addr = rt; wb_data = {31'd0, rs_val < imm_sext}; end
      OpAndi:  begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val & imm_zext; end
      OpOri:   begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val | imm_zext; end
      OpXori:  begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val ^ imm_zext; end
      OpLui:   begin wb_en = 1'b1; wb_addr = rt; wb_data = {imm, 16'd0}; end
      OpLw:    begin wb_en = 1'b1; wb_addr = rt; wb_data = data_readdata; data_read = 1'b1; end
      OpSw:    data_write = 1'b1;
      default: ;
    endcase
  end

  // npc_q holds the address after the delay slot; landing on 0 halts once the slot retires.
  always_comb begin
    pc_d     = npc_q;
    npc_d    = jump_taken ? jump_target : npc_q + 32'd4;
    active_d = (npc_q != 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= ResetVector;
      npc_q    <= ResetVector + 32'd4;
      active_q <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (update) begin
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      active_q <= active_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign active         = active_q;
  assign instr_address  = pc_q;
  assign data_address   = rs_val + imm_sext;
  assign data_writedata = rt_val;

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// Drives instructions straight onto the fetch bus and checks against an ISA-level interpreter.
module tb_mips_cpu_harvard;

  logic        clk, reset, clk_enable, active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;

  mips_cpu_harvard dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .active         (active),
    .register_v0    (register_v0),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_pc, m_npc, m_hi, m_lo;
  logic        m_active;

  localparam logic [31:0] Nop = 32'h0000_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = 32'hBFC0_0000;
    m_npc = 32'hBFC0_0004;
    m_hi = '0;
    m_lo = '0;
    m_active = 1'b1;
  endtask

  // Architectural semantics of one retired instruction.
  task automatic model_exec(input logic [31:0] ins, input logic [31:0] rdd);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, wa;
    logic [31:0] a, b, se, ze, val, nxt, seq;
    logic [63:0] p;
    logic        we;
    longint      sa, sb;
    if (!m_active) return;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    a = m_reg[rs]; b = m_reg[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'd0, ins[15:0]};
    seq = m_pc + 32'd4;
    nxt = m_npc + 32'd4;
    we = 1'b0; wa = rt; val = '0;
    case (op)
      6'd0: begin
        wa = rd;
        case (fn)
          6'd0:  begin we = 1; val = b << sh; end
          6'd2:  begin we = 1; val = b >> sh; end
          6'd3:  begin we = 1; val = $signed(b) >>> sh; end
          6'd8:  nxt = a;
          6'd9:  begin nxt = a; we = 1; val = m_pc + 32'd8; end
          6'd16: begin we = 1; val = m_hi; end
          6'd17: m_hi = a;
          6'd18: begin we = 1; val = m_lo; end
          6'd19: m_lo = a;
          6'd24: begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0];
          end
          6'd25: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
          6'd33: begin we = 1; val = a + b; end
          6'd35: begin we = 1; val = a - b; end
          6'd36: begin we = 1; val = a & b; end
          6'd37: begin we = 1; val = a | b; end
          6'd38: begin we = 1; val = a ^ b; end
          6'd42: begin we = 1; val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          6'd43: begin we = 1; val = (a < b) ? 32'd1 : 32'd0; end
          default: ;
        endcase
      end
      6'd2:  nxt = {seq[31:28], ins[25:0], 2'b00};
      6'd3:  begin nxt = {seq[31:28], ins[25:0], 2'b00}; we = 1; wa = 5'd31; val = m_pc + 32'd8; end
      6'd4:  if (a == b) nxt = seq + (se << 2);
      6'd5:  if (a != b) nxt = seq + (se << 2);
      6'd9:  begin we = 1; val = a + se; end
      6'd10: begin we = 1; val = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'd11: begin we = 1; val = (a < se) ? 32'd1 : 32'd0; end
      6'd12: begin we = 1; val = a & ze; end
      6'd13: begin we = 1; val = a | ze; end
      6'd14: begin we = 1; val = a ^ ze; end
      6'd15: begin we = 1; val = {ins[15:0], 16'd0}; end
      6'd35: begin we = 1; val = rdd; end
      default: ;
    endcase
    if (we && wa != 5'd0) m_reg[wa] = val;
    if (m_npc == 32'd0) m_active = 1'b0;
    m_pc = m_npc;
    m_npc = nxt;
  endtask

  // Present one instruction for a cycle, check outputs mid-cycle, then let the edge retire it.
  task automatic step(input logic [31:0] ins, input logic [31:0] rdd, input logic en,
                      input string tag);
    logic [5:0] op;
    @(negedge clk);
    instr_readdata = ins;
    data_readdata  = rdd;
    clk_enable     = en;
    #1;
    op = ins[31:26];
    chk({tag, " pc"}, instr_address, m_pc);
    chk({tag, " active"}, {31'd0, active}, {31'd0, m_active});
    chk({tag, " v0"}, register_v0, m_reg[2]);
    chk({tag, " data_read"}, {31'd0, data_read}, {31'd0, op == 6'd35});
    chk({tag, " data_write"}, {31'd0, data_write}, {31'd0, op == 6'd43});
    if (op == 6'd35 || op == 6'd43)
      chk({tag, " data_address"}, data_address, m_reg[ins[25:21]] + {{16{ins[15]}}, ins[15:0]});
    if (op == 6'd43) chk({tag, " data_writedata"}, data_writedata, m_reg[ins[20:16]]);
    if (en) model_exec(ins, rdd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clk_enable = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] rand_instr(input bit ctrl_ok);
    logic [5:0] fns [17] = '{6'd0, 6'd2, 6'd3, 6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25,
                             6'd33, 6'd35, 6'd36, 6'd37, 6'd38, 6'd42, 6'd43, 6'd1};
    logic [5:0] ops [10] = '{6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43,
                             6'd32};
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int          k;
    rs  = 5'($urandom);
    rt  = ($urandom_range(0, 2) == 0) ? 5'd2 : 5'($urandom);
    rd  = ($urandom_range(0, 2) == 0) ? 5'd2 : 5'($urandom);
    imm = 16'($urandom);
    k = int'($urandom_range(0, ctrl_ok ? 9 : 7));
    case (k)
      0, 1, 2: return enc_r(rs, rt, rd, 5'($urandom), fns[$urandom_range(0, 16)]);
      3, 4, 5: return enc_i(ops[$urandom_range(0, 9)], rs, rt, imm);
      6:       return enc_i(6'd35, rs, rt, imm);
      7:       return enc_i(6'd43, rs, rt, imm);
      8:       return enc_i($urandom_range(0, 1) ? 6'd4 : 6'd5, rs,
                            $urandom_range(0, 1) ? rs : rt, imm);
      default: return {$urandom_range(0, 1) ? 6'd2 : 6'd3, 26'($urandom)};
    endcase
  endfunction

  initial begin
    logic [31:0] d, ins;
    bit          last_ctrl;
    reset = 1'b0;
    clk_enable = 1'b1;
    instr_readdata = Nop;
    data_readdata = '0;
    model_reset();

    do_reset();
    for (int i = 0; i < 4; i++) step(Nop, 32'd0, 1'b1, "nop");
    chk("nop pc after 4", instr_address, 32'hBFC0_000C);

    step(enc_i(6'd35, 5'd0, 5'd2, 16'd0), 32'h1234_5678, 1'b1, "lw v0");
    chk("lw address", data_address, 32'd0);
    step(Nop, 32'd0, 1'b1, "nop");
    chk("lw v0 value", register_v0, 32'h1234_5678);

    step(enc_i(6'd35, 5'd0, 5'd3, 16'd0), 32'hFFFF_FFFF, 1'b1, "lw r3");
    step(enc_i(6'd35, 5'd0, 5'd4, 16'd4), 32'd2, 1'b1, "lw r4");
    step(enc_r(5'd3, 5'd4, 5'd0, 5'd0, 6'd24), 32'd0, 1'b1, "mult");
    step(enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'd18), 32'd0, 1'b1, "mflo");
    step(Nop, 32'd0, 1'b1, "nop");
    chk("mult lo", register_v0, 32'hFFFF_FFFE);
    step(enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'd16), 32'd0, 1'b1, "mfhi");
    step(Nop, 32'd0, 1'b1, "nop");
    chk("mult hi", register_v0, 32'hFFFF_FFFF);
    step(enc_r(5'd3, 5'd4, 5'd0, 5'd0, 6'd25), 32'd0, 1'b1, "multu");
    step(enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'd18), 32'd0, 1'b1, "mflo");
    step(Nop, 32'd0, 1'b1, "nop");
    chk("multu lo", register_v0, 32'hFFFF_FFFE);
    step(enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'd16), 32'd0, 1'b1, "mfhi");
    step(Nop, 32'd0, 1'b1, "nop");
    chk("multu hi", register_v0, 32'h0000_0001);

    d = 32'h0;
    for (int r = 3; r < 32; r++) begin
      d = d + 32'hDCBA_1234;
      step(enc_i(6'd35, 5'd0, 5'(r), 16'(r * 4)), d, 1'b1, "lw chain");
    end
    for (int r = 3; r < 31; r++) begin
      step(enc_r(5'(r), 5'(r + 1), 5'd0, 5'd0, 6'd24), 32'd0, 1'b1, "chain mult");
      step(enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'd18), 32'd0, 1'b1, "chain mflo");
      step(enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'd16), 32'd0, 1'b1, "chain mfhi");
    end

    last_ctrl = 1'b0;
    for (int n = 0; n < 500; n++) begin
      ins = rand_instr(!last_ctrl);
      last_ctrl = (ins[31:26] inside {6'd2, 6'd3, 6'd4, 6'd5});
      step(ins, $urandom, $urandom_range(0, 9) != 0, "rand");
    end

    step(enc_i(6'd9, 5'd0, 5'd2, 16'd3), 32'd0, 1'b1, "addiu 3");
    step(enc_i(6'd9, 5'd0, 5'd2, 16'd7), 32'd0, 1'b0, "gated addiu");
    step(Nop, 32'd0, 1'b1, "after gate");
    chk("gated v0", register_v0, 32'd3);

    step(enc_i(6'd4, 5'd0, 5'd0, 16'd64), 32'd0, 1'b1, "beq");
    do_reset();
    step(Nop, 32'd0, 1'b1, "post reset");
    chk("reset pc", instr_address, 32'hBFC0_0000);
    step(Nop, 32'd0, 1'b1, "post reset");
    chk("branch dropped", instr_address, 32'hBFC0_0004);

    step(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'd8), 32'd0, 1'b1, "jr r0");
    step(enc_i(6'd9, 5'd0, 5'd2, 16'd5), 32'd0, 1'b1, "delay slot");
    step(enc_i(6'd9, 5'd0, 5'd2, 16'd9), 32'd0, 1'b1, "halted");
    chk("halt v0", register_v0, 32'd5);
    chk("halt active", {31'd0, active}, 32'd0);
    step(Nop, 32'd0, 1'b1, "halted");
    step(Nop, 32'd0, 1'b1, "halted");
    chk("halt v0 frozen", register_v0, 32'd5);
    chk("halt pc frozen", instr_address, 32'd0);

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
